regfile_wb_arb: RTL
===================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter NREG, default 32, architectural register count; address width fixed at 5.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global pipeline-ready; low freezes the block.
REQ-006 alu_req  input  1  ALU writeback request; held until granted.
REQ-007 alu_addr  input  5  ALU destination register.
REQ-008 alu_data  input  XLEN  ALU result.
REQ-009 alu_gnt  output  1  ALU request accepted this cycle (combinational).
REQ-010 mem_req, mem_addr, mem_data, mem_gnt: same as REQ-006..009 for the load unit.
REQ-011 issue_valid  input  1  instruction issued this cycle with a destination.
REQ-012 issue_rd  input  5  destination of the issued instruction.
REQ-013 we  output  1  registered write enable to the register file.
REQ-014 waddr  output  5  registered write address.
REQ-015 wdata  output  XLEN  registered write data.
REQ-016 busy  output  NREG  scoreboard; bit i high = write to xi pending.

Function
REQ-017 Single write port shared by ALU and MEM sources; at most one grant per cycle.
REQ-018 Grant only when rdy high; requester SHALL NOT change addr/data while req high and gnt low.
REQ-019 Both requesting: grant the source not granted most recently (1-bit round-robin pointer `last`); one requesting: grant it.
REQ-020 `last` updates only on a grant; reset value = MEM (ALU wins first contention).
REQ-021 Granted request registered to we/waddr/wdata at the next rising edge; latency 1 cycle from grant to we.
REQ-022 Grant with addr 0: request consumed, gnt asserted, we stays 0 next cycle (x0 write dropped).
REQ-023 No grant in a cycle: we = 0 next cycle; waddr/wdata hold previous values.
REQ-024 busy[r] set at edge where issue_valid=1, rdy=1, issue_rd=r, r!=0.
REQ-025 busy[r] cleared at edge where registered write to r is emitted (grant of addr r).
REQ-026 Set and clear of same r at the same edge: set wins, busy[r]=1.
REQ-027 busy[0] constantly 0.
REQ-028 rdy low: no grants, busy, `last`, waddr, wdata held, we forced 0 at next edge.
REQ-029 Clearing a busy bit that is already 0 is legal; no error state.
REQ-030 Starvation bound: a continuously asserted request is granted within 2 rdy-high cycles.

Reset
REQ-031 rst low asynchronously forces we=0, waddr=0, wdata=0, busy=0, last=MEM; gnt outputs 0 while rst low.
REQ-032 Reset mid-operation drops any pending grant/write; no write issues in the first edge after rst release unless a grant occurs in that cycle.
REQ-033 rst low overrides rdy and all requests.

Verification
REQ-034 Reset, then alu_req=1 addr=5 data=0x11 alone -> alu_gnt=1 same cycle; next edge we=1 waddr=5 wdata=0x11.
REQ-035 Both requesting every cycle from reset (ALU addr 3, MEM addr 4) -> grants alternate ALU, MEM, ALU, MEM; we pulses every cycle.
REQ-036 issue_valid rd=7, then MEM write addr 7 two cycles later -> busy[7]=1 after issue edge, 0 after write edge.
REQ-037 issue_valid rd=9 at same edge as write to 9 -> busy[9]=1 afterwards; issue rd=0 -> busy stays 0.
REQ-038 alu_req addr=0 data=0xFF -> alu_gnt=1, we=0 next cycle, registers unchanged.
REQ-039 rdy=0 for 3 cycles with both requests high -> no gnt, we=0; rdy=1 -> arbitration resumes with pointer unchanged; assert rst low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_wb_arb_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_arb_if : writeback request/grant, issue and register-file bus
// Rev 1.0 - initial release
// ============================================================================
interface regfile_wb_arb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  logic            alu_req;
  logic [4:0]      alu_addr;
  logic [XLEN-1:0] alu_data;
  logic            alu_gnt;
  logic            mem_req;
  logic [4:0]      mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            mem_gnt;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [NREG-1:0] busy;

  modport master (
    output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
           issue_valid, issue_rd,
    input  alu_gnt, mem_gnt, we, waddr, wdata, busy
  );

  modport slave (
    input  alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
           issue_valid, issue_rd,
    output alu_gnt, mem_gnt, we, waddr, wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arb.sv
`default_nettype none
// ============================================================================
// regfile_wb_arb : round-robin ALU/MEM writeback arbiter with busy scoreboard
// Rev 1.0 - initial release
// ============================================================================
module regfile_wb_arb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  regfile_wb_arb_if.slave  bus
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e            last_q, last_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            alu_gnt, mem_gnt;
  logic            any_gnt;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] set_mask, clr_mask;

  // Grants are gated by rst so they drop the moment reset asserts.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (rst && rdy) begin
      alu_gnt = bus.alu_req && (!bus.mem_req || last_q == SRC_MEM);
      mem_gnt = bus.mem_req && (!bus.alu_req || last_q == SRC_ALU);
    end
  end

  always_comb begin
    any_gnt  = alu_gnt || mem_gnt;
    win_addr = alu_gnt ? bus.alu_addr : bus.mem_addr;
    win_data = alu_gnt ? bus.alu_data : bus.mem_data;

    last_d  = last_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_gnt) last_d = SRC_ALU;
    if (mem_gnt) last_d = SRC_MEM;
    // x0 grants are consumed but never reach the register file.
    if (any_gnt && win_addr != 5'd0) begin
      we_d    = 1'b1;
      waddr_d = win_addr;
      wdata_d = win_data;
    end

    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rdy && bus.issue_valid && bus.issue_rd == i[4:0]) set_mask[i] = 1'b1;
      if (any_gnt && win_addr == i[4:0])                   clr_mask[i] = 1'b1;
    end
    // Set is applied after clear so a same-edge issue keeps the bit high.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= SRC_MEM;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.alu_gnt = alu_gnt;
  assign bus.mem_gnt = mem_gnt;
  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire
